fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined core: the producer side of the IF/ID pipeline register.
- Owns the PC and drives a ready/ack instruction-memory port.
- Buffers one fetched instruction with its PC+4, presenting instr/pc_plus4 plus a valid flag to the IF/ID register.
- Honours hazard-unit stall and execute-stage redirects (branch/jump). Any in-flight memory request made stale by a redirect is discarded.

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues imem requests, buffers one instruction for IF/ID.
// Latency: zero-wait memory gives one instruction per cycle; a redirect requests the target one cycle later.
// Backpressure: stall_i with a full buffer holds the request low; an issued request is held until its ack.
module fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic [WIDTH-1:0] instr_of32,
    output logic [WIDTH-1:0] pc_plus4_of32,
    output logic             instr_valid_o
);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

    logic [1:0]       state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] req_addr_q;
    logic [WIDTH-1:0] ibuf_instr_q;
    logic [WIDTH-1:0] ibuf_pc4_q;
    logic             ibuf_valid_q;

    logic             slot_avail;
    logic             req;
    logic [WIDTH-1:0] addr;
    logic             capture;
    logic             consume;
    logic [WIDTH-1:0] redirect_target;
    logic [WIDTH-1:0] pc_next_seq;

    assign redirect_target = redirect_pc_i & ALIGN_MASK;
    assign pc_next_seq     = pc_q + PC_STEP;

    always_comb begin
        slot_avail = !ibuf_valid_q || !stall_i;
        req        = 1'b1;
        addr       = req_addr_q;
        if (state_q == S_RUN) begin
            req  = slot_avail;
            addr = pc_q;
        end
        // A response to a request made stale by a redirect never reaches the buffer.
        capture = req && imem_ack_i && !redirect_i && (state_q != S_DISCARD);
        consume = ibuf_valid_q && !stall_i;
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = addr;
    assign instr_of32    = ibuf_instr_q;
    assign pc_plus4_of32 = ibuf_pc4_q;
    assign instr_valid_o = ibuf_valid_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_RUN;
            req_addr_q <= RESET_PC;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (req && !imem_ack_i) begin
                        req_addr_q <= pc_q;
                        state_q    <= redirect_i ? S_DISCARD : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack_i) begin
                        state_q <= S_RUN;
                    end else if (redirect_i) begin
                        state_q <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack_i) begin
                        state_q <= S_RUN;
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    // In S_WAIT pc_q still equals the outstanding address, so pc_q+4 is the captured PC+4.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q <= RESET_PC;
        end else if (redirect_i) begin
            pc_q <= redirect_target;
        end else if (capture) begin
            pc_q <= pc_next_seq;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ibuf_instr_q <= '0;
            ibuf_pc4_q   <= '0;
            ibuf_valid_q <= 1'b0;
        end else if (redirect_i) begin
            ibuf_instr_q <= '0;
            ibuf_pc4_q   <= '0;
            ibuf_valid_q <= 1'b0;
        end else if (capture) begin
            ibuf_instr_q <= imem_rdata_i;
            ibuf_pc4_q   <= pc_next_seq;
            ibuf_valid_q <= 1'b1;
        end else if (consume) begin
            ibuf_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model of PC, outstanding request and buffer,
// driven by directed scenarios followed by randomized stall/redirect/reset/latency traffic.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (rpc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (ack),
        .imem_rdata_i  (rdata),
        .instr_of32    (instr),
        .pc_plus4_of32 (pc4),
        .instr_valid_o (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: next fetch PC, one outstanding request (address, stale flag), one buffered instruction.
    logic        model_ok = 1'b0;
    logic [31:0] m_pc;
    logic        m_buf_v;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        o_act;
    logic [31:0] o_addr;
    logic        o_stale;

    // Memory side: latency counter for the request currently presented.
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;

    logic        ob_req;
    logic [31:0] ob_addr;
    logic        ob_valid;
    logic [31:0] ob_instr;
    logic [31:0] ob_pc4;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, answer memory, advance the model.
    task automatic cycle(input bit rst, input bit st, input bit rd, input logic [31:0] rp, input int lat);
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        useful;
        @(negedge clk);
        reset    = rst;
        stall    = st;
        redirect = rd;
        rpc      = rp;
        ack      = 1'b0;
        rdata    = 32'h0;
        #1;
        ob_req   = imem_req;
        ob_addr  = imem_addr;
        ob_valid = valid;
        ob_instr = instr;
        ob_pc4   = pc4;

        exp_req  = o_act ? 1'b1 : (!m_buf_v || !st);
        exp_addr = o_act ? o_addr : m_pc;
        if (model_ok) begin
            chk("imem_req", {31'b0, ob_req}, {31'b0, exp_req});
            if (exp_req) chk("imem_addr", ob_addr, exp_addr);
            chk("instr_valid", {31'b0, ob_valid}, {31'b0, m_buf_v});
            chk("instr", ob_instr, m_instr);
            chk("pc_plus4", ob_pc4, m_pc4);
        end

        if (rst) begin
            mem_busy = 1'b0;
        end else if (ob_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
            end
            if (mem_cnt == 0) begin
                ack      = 1'b1;
                rdata    = $urandom;
                mem_busy = 1'b0;
            end else begin
                mem_cnt--;
            end
        end

        if (rst) begin
            m_pc     = 32'h0;
            m_buf_v  = 1'b0;
            m_instr  = 32'h0;
            m_pc4    = 32'h0;
            o_act    = 1'b0;
            o_addr   = 32'h0;
            o_stale  = 1'b0;
            model_ok = 1'b1;
        end else begin
            useful = exp_req && ack && !(o_act && o_stale) && !rd;
            if (rd) begin
                m_pc    = rp & 32'hFFFF_FFFC;
                m_buf_v = 1'b0;
                m_instr = 32'h0;
                m_pc4   = 32'h0;
            end else if (useful) begin
                m_buf_v = 1'b1;
                m_instr = rdata;
                m_pc4   = exp_addr + 32'd4;
                m_pc    = exp_addr + 32'd4;
            end else if (m_buf_v && !st) begin
                m_buf_v = 1'b0;
            end
            if (exp_req && !ack) begin
                o_stale = (o_act ? o_stale : 1'b0) | rd;
                o_act   = 1'b1;
                o_addr  = exp_addr;
            end else if (exp_req && ack) begin
                o_act = 1'b0;
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        rpc      = 32'h0;
        ack      = 1'b0;
        rdata    = 32'h0;

        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);

        // Zero-wait streaming from RESET_PC.
        cycle(0, 0, 0, 0, 0);
        chk("t1 req", {31'b0, ob_req}, 32'd1);
        chk("t1 addr0", ob_addr, 32'h0);
        chk("t1 valid0", {31'b0, ob_valid}, 32'd0);
        chk("t1 instr0", ob_instr, 32'h0);
        cycle(0, 0, 0, 0, 0);
        chk("t1 addr4", ob_addr, 32'h4);
        chk("t1 valid1", {31'b0, ob_valid}, 32'd1);
        chk("t1 pc4_4", ob_pc4, 32'h4);
        cycle(0, 0, 0, 0, 0);
        chk("t1 addr8", ob_addr, 32'h8);
        chk("t1 pc4_8", ob_pc4, 32'h8);
        cycle(0, 0, 0, 0, 0);
        chk("t1 pc4_12", ob_pc4, 32'hC);

        // Three-cycle wait at 0x10.
        cycle(0, 0, 1, 32'h10, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 2);
            chk("t2 hold req", {31'b0, ob_req}, 32'd1);
            chk("t2 hold addr", ob_addr, 32'h10);
        end
        cycle(0, 0, 0, 0, 0);
        chk("t2 valid", {31'b0, ob_valid}, 32'd1);
        chk("t2 pc4", ob_pc4, 32'h14);
        chk("t2 next addr", ob_addr, 32'h14);

        // Stall with a full buffer.
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0, 0);
            chk("t3 stall req", {31'b0, ob_req}, 32'd0);
            chk("t3 stall pc4", ob_pc4, 32'h18);
        end
        cycle(0, 0, 0, 0, 0);
        chk("t3 release req", {31'b0, ob_req}, 32'd1);
        chk("t3 release addr", ob_addr, 32'h18);

        // Redirect while waiting at 0x20.
        cycle(0, 0, 1, 32'h20, 0);
        chk("t3 next pc4", ob_pc4, 32'h1C);
        cycle(0, 0, 0, 0, 3);
        chk("t4 wait addr", ob_addr, 32'h20);
        cycle(0, 0, 1, 32'h103, 0);
        cycle(0, 0, 0, 0, 0);
        chk("t4 discard addr", ob_addr, 32'h20);
        cycle(0, 0, 0, 0, 0);
        chk("t4 stale valid", {31'b0, ob_valid}, 32'd0);
        cycle(0, 0, 0, 0, 1);
        chk("t4 target addr", ob_addr, 32'h100);
        chk("t4 target valid", {31'b0, ob_valid}, 32'd0);
        cycle(0, 0, 0, 0, 0);
        chk("t4 pending valid", {31'b0, ob_valid}, 32'd0);
        cycle(0, 0, 0, 0, 0);
        chk("t4 valid", {31'b0, ob_valid}, 32'd1);
        chk("t4 pc4", ob_pc4, 32'h104);

        // Redirect under stall with a full buffer.
        cycle(0, 1, 1, 32'h40, 0);
        chk("t5 pre req", {31'b0, ob_req}, 32'd0);
        cycle(0, 1, 0, 0, 0);
        chk("t5 flush valid", {31'b0, ob_valid}, 32'd0);
        chk("t5 flush instr", ob_instr, 32'h0);
        chk("t5 flush pc4", ob_pc4, 32'h0);
        chk("t5 addr", ob_addr, 32'h40);

        // Reset in the middle of a wait, then PC wraparound.
        cycle(0, 0, 1, 32'h8, 0);
        cycle(0, 0, 0, 0, 3);
        chk("t6 wait addr", ob_addr, 32'h8);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        chk("t6 reset req", {31'b0, ob_req}, 32'd1);
        chk("t6 reset addr", ob_addr, 32'h0);
        chk("t6 reset valid", {31'b0, ob_valid}, 32'd0);
        cycle(0, 0, 1, 32'hFFFF_FFFC, 0);
        cycle(0, 0, 0, 0, 0);
        chk("t6 top addr", ob_addr, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0, 0);
        chk("t6 wrap pc4", ob_pc4, 32'h0);
        chk("t6 wrap addr", ob_addr, 32'h0);
        chk("t6 wrap valid", {31'b0, ob_valid}, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | {28'h0, 4'($urandom)};
            cycle(($urandom_range(0, 127) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 11) == 0),
                  tgt, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
